i2c_txn_arbiter: RTL and testbench

Round-robin arbiter that shares the single I2C master transaction port (enable / i2c_addr / i2c_rw / i2c_data_in / i2c_data_out / i2c_ready) of the I2C-APB bridge top among NREQ requesters. It accepts one 7-bit-address, 1-byte transaction at a time, sequences the master's enable pulse and ready handshake, and returns read data and completion status to the originating requester. It sits between the requesting agents and the bridge top.

---
 rtl/i2c_txn_arbiter_if.sv | 38 +++
 rtl/i2c_txn_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_txn_arbiter_if.sv
// Bundle of requester-side and bridge-side signals around the I2C
// transaction arbiter. The master modport is the arbiter's view.
// The slave modport is the environment's view: the requesters plus
// the bridge top.
interface i2c_txn_arbiter_if #(
    parameter int NREQ = 4
);
    // requester side
    logic [NREQ-1:0]   req_valid;
    logic [7*NREQ-1:0] req_addr;
    logic [NREQ-1:0]   req_rw;
    logic [8*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [2:0]        rsp_id;
    logic [7:0]        rsp_rdata;
    logic              rsp_err;
    logic              busy;
    // bridge side
    logic              enable;
    logic [6:0]        i2c_addr;
    logic              i2c_rw;
    logic [7:0]        i2c_data_in;
    logic [7:0]        i2c_data_out;
    logic              i2c_ready;

    modport master (
        input  req_valid, req_addr, req_rw, req_wdata, i2c_data_out, i2c_ready,
        output req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, busy,
               enable, i2c_addr, i2c_rw, i2c_data_in
    );

    modport slave (
        output req_valid, req_addr, req_rw, req_wdata, i2c_data_out, i2c_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, busy,
               enable, i2c_addr, i2c_rw, i2c_data_in
    );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter in front of the single I2C master transaction port.
// It serves one 7-bit-address, 1-byte transaction at a time. Each
// transaction goes through IDLE -> ISSUE (enable held EN_CYCLES) ->
// WAIT (ready handshake) -> DONE (one-cycle response).
// Optional feature: define I2C_ARB_TIMEOUT_EN to add a watchdog.
// The watchdog aborts a transaction TIMEOUT cycles after grant and
// reports it with rsp_err.
module i2c_txn_arbiter #(
    parameter int NREQ      = 4,
    parameter int EN_CYCLES = 20,
    parameter int TIMEOUT   = 4096
) (
    input logic               clk,
    input logic               rst_n,
    i2c_txn_arbiter_if.master bus
);

    localparam int CNT_W = (EN_CYCLES > 2) ? $clog2(EN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EN_CYCLES - 1);
    localparam logic [2:0] LAST_INIT = 3'(NREQ - 1);

    // Parameter sanity checks at elaboration time.
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("i2c_txn_arbiter: NREQ must be in 2..8");
    end
    if (EN_CYCLES < 1) begin : g_bad_en
        $error("i2c_txn_arbiter: EN_CYCLES must be at least 1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("i2c_txn_arbiter: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t            state_reg;
    logic [2:0]        last_grant_reg;
    logic              busy_seen_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              enable_reg;
    logic [6:0]        addr_reg;
    logic              rw_reg;
    logic [7:0]        wdata_reg;
    logic [NREQ-1:0]   req_ready_reg;
    logic              rsp_valid_reg;
    logic [2:0]        rsp_id_reg;
    logic [7:0]        rsp_rdata_reg;
    logic              busy_reg;

    logic              grant_found;
    logic [2:0]        grant_idx;
    logic [6:0]        grant_addr;
    logic              grant_rw;
    logic [7:0]        grant_wdata;
    logic [NREQ-1:0]   grant_onehot;
    logic              wait_done;

    // Rotating priority search: first valid requester after last_grant, wrapping.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_addr  = '0;
        grant_rw    = 1'b0;
        grant_wdata = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant_reg) + k) % NREQ;
            if (!grant_found && bus.req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = 3'(idx);
                grant_addr  = bus.req_addr[idx*7 +: 7];
                grant_rw    = bus.req_rw[idx];
                grant_wdata = bus.req_wdata[idx*8 +: 8];
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
        assign grant_onehot[gi] = grant_found && (grant_idx == 3'(gi));
    end

    // A completion counts only after the bridge has shown it was busy.
    // A high ready before that is the stale idle level from earlier.
    assign wait_done = (state_reg == ST_WAIT) && bus.i2c_ready && busy_seen_reg;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0] wd_reg;
    logic            rsp_err_reg;
    assign bus.rsp_err = rsp_err_reg;
`else
    assign bus.rsp_err = 1'b0;
`endif

    // Transaction sequencer with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= LAST_INIT;
            busy_seen_reg  <= 1'b0;
            cnt_reg        <= '0;
            enable_reg     <= 1'b0;
            addr_reg       <= '0;
            rw_reg         <= 1'b0;
            wdata_reg      <= '0;
            req_ready_reg  <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= '0;
            rsp_rdata_reg  <= '0;
            busy_reg       <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            wd_reg         <= '0;
            rsp_err_reg    <= 1'b0;
`endif
        end else begin
            req_ready_reg <= '0;
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (grant_found) begin
                        req_ready_reg  <= grant_onehot;
                        addr_reg       <= grant_addr;
                        rw_reg         <= grant_rw;
                        wdata_reg      <= grant_wdata;
                        last_grant_reg <= grant_idx;
                        busy_seen_reg  <= 1'b0;
                        cnt_reg        <= CNT_LOAD;
                        enable_reg     <= 1'b1;
                        busy_reg       <= 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
                        wd_reg         <= '0;
`endif
                        state_reg      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!bus.i2c_ready) busy_seen_reg <= 1'b1;
                    if (cnt_reg == '0) begin
                        enable_reg <= 1'b0;
                        state_reg  <= ST_WAIT;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (!bus.i2c_ready) busy_seen_reg <= 1'b1;
                    if (wait_done) begin
                        rsp_rdata_reg <= rw_reg ? bus.i2c_data_out : 8'h00;
                        rsp_valid_reg <= 1'b1;
                        rsp_id_reg    <= last_grant_reg;
`ifdef I2C_ARB_TIMEOUT_EN
                        rsp_err_reg   <= 1'b0;
`endif
                        state_reg     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
`ifdef I2C_ARB_TIMEOUT_EN
            // Watchdog: a real completion on the same edge takes precedence.
            if ((state_reg == ST_ISSUE || state_reg == ST_WAIT) && !wait_done) begin
                if (wd_reg == WD_LAST) begin
                    enable_reg    <= 1'b0;
                    rsp_valid_reg <= 1'b1;
                    rsp_id_reg    <= last_grant_reg;
                    rsp_rdata_reg <= 8'h00;
                    rsp_err_reg   <= 1'b1;
                    state_reg     <= ST_DONE;
                end else begin
                    wd_reg <= wd_reg + 1'b1;
                end
            end
`endif
        end
    end

    assign bus.req_ready   = req_ready_reg;
    assign bus.rsp_valid   = rsp_valid_reg;
    assign bus.rsp_id      = rsp_id_reg;
    assign bus.rsp_rdata   = rsp_rdata_reg;
    assign bus.busy        = busy_reg;
    assign bus.enable      = enable_reg;
    assign bus.i2c_addr    = addr_reg;
    assign bus.i2c_rw      = rw_reg;
    assign bus.i2c_data_in = wdata_reg;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Self-checking bench for i2c_txn_arbiter. The bridge is modelled
// abstractly as a per-transaction ready pattern. Expected grants,
// completion cycles and response data come from the arbiter's
// rules, evaluated on plain integers.
module tb_i2c_txn_arbiter;
    localparam int NREQ = 4;
    localparam int EN   = 20;
    localparam int TO   = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_txn_arbiter_if #(.NREQ(NREQ)) bus ();

    i2c_txn_arbiter #(.NREQ(NREQ), .EN_CYCLES(EN), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_last = NREQ - 1;
    logic [6:0] t_addr [NREQ];
    logic       t_rw   [NREQ];
    logic [7:0] t_wdata[NREQ];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reqs(input logic [NREQ-1:0] mask);
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i*7 +: 7]  = t_addr[i];
            bus.req_rw[i]           = t_rw[i];
            bus.req_wdata[i*8 +: 8] = t_wdata[i];
        end
        bus.req_valid = mask;
    endtask

    // Next winner: the first requesting index met when counting upward
    // from the previous winner, wrapping around.
    function automatic int model_pick(input logic [NREQ-1:0] mask);
        int i;
        for (int k = 1; k <= NREQ; k++) begin
            i = (model_last + k) % NREQ;
            if (mask[i]) return i;
        end
        return -1;
    endfunction

    // Bridge ready level for the edge k cycles after grant.
    function automatic bit rdy_at(input int k, input int ls, input int ll);
        return !(k >= ls && k < ls + ll);
    endfunction

    // Completion edge: the first edge after enable is done where ready is
    // high and a low was seen at some earlier edge after grant.
    function automatic int model_done(input int ls, input int ll);
        for (int k = EN + 1; k < 2000; k++)
            if (rdy_at(k, ls, ll) && ll > 0 && ls >= 1 && ls < k) return k;
        return -1;
    endfunction

    task automatic run_txn(input int ls, input int ll, input logic [7:0] rdval,
                           input bit hold, output int gid, output int gcyc);
        int exp_g, exp_k, rsp_k, en_cnt, rr_cnt;
        bit got;
        gid   = -1;
        gcyc  = cyc;
        exp_g = model_pick(bus.req_valid);
        got   = 1'b0;
        for (int w = 0; w < 60 && !got; w++) begin
            tick();
            if (bus.req_ready != '0) got = 1'b1;
        end
        check("grant_seen", 32'(got), 32'd1);
        if (!got || exp_g < 0) return;
        gcyc = cyc;
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) gid = i;
        check("req_ready", 32'(bus.req_ready), 32'd1 << exp_g);
        check("enable_on_grant", 32'(bus.enable), 32'd1);
        check("busy_on_grant", 32'(bus.busy), 32'd1);
        check("i2c_addr", 32'(bus.i2c_addr), 32'(t_addr[exp_g]));
        check("i2c_rw", 32'(bus.i2c_rw), 32'(t_rw[exp_g]));
        check("i2c_data_in", 32'(bus.i2c_data_in), 32'(t_wdata[exp_g]));
        model_last = exp_g;
        if (!hold) bus.req_valid[exp_g] = 1'b0;
        exp_k  = model_done(ls, ll);
        en_cnt = 1;
        rr_cnt = 0;
        rsp_k  = -1;
        for (int k = 1; k <= 400 && rsp_k < 0; k++) begin
            bus.i2c_ready    = rdy_at(k, ls, ll);
            bus.i2c_data_out = rdval;
            tick();
            if (bus.enable) en_cnt++;
            if (bus.req_ready != '0) rr_cnt++;
            if (bus.rsp_valid) rsp_k = k;
        end
        check("rsp_cycle", rsp_k, exp_k);
        check("rsp_id", 32'(bus.rsp_id), exp_g);
        check("rsp_rdata", 32'(bus.rsp_rdata), t_rw[exp_g] ? 32'(rdval) : 32'h0);
        check("rsp_err", 32'(bus.rsp_err), 32'd0);
        check("enable_cycles", en_cnt, EN);
        check("req_ready_pulse", rr_cnt, 0);
        check("addr_stable", 32'(bus.i2c_addr), 32'(t_addr[exp_g]));
        check("wdata_stable", 32'(bus.i2c_data_in), 32'(t_wdata[exp_g]));
        bus.i2c_ready = 1'b1;
        tick();
        check("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
        check("busy_clear", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int gid, gc, prev_gc, rk, ls, ll;
        bit got;
        int exp_rr[6];
        exp_rr = '{0, 1, 2, 0, 2, 0};

        for (int i = 0; i < NREQ; i++) begin
            t_addr[i] = '0; t_rw[i] = 1'b0; t_wdata[i] = '0;
        end
        apply_reqs('0);
        bus.i2c_ready    = 1'b1;
        bus.i2c_data_out = 8'h00;
        rst_n = 1'b0;
        repeat (3) tick();

        // reset state
        check("rst_enable", 32'(bus.enable), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_i2c_addr", 32'(bus.i2c_addr), 32'd0);
        check("rst_i2c_rw", 32'(bus.i2c_rw), 32'd0);
        check("rst_i2c_data_in", 32'(bus.i2c_data_in), 32'd0);
        rst_n = 1'b1;
        tick();

        // single write from requester 0
        t_addr[0] = 7'h50; t_wdata[0] = 8'hA5; t_rw[0] = 1'b0;
        apply_reqs(4'b0001);
        run_txn(3, 6, 8'h3C, 1'b0, gid, gc);
        check("write_gid", gid, 0);
        $display("txn write: id=%0d rdata=%02h err=%0d", bus.rsp_id, bus.rsp_rdata, bus.rsp_err);

        // single read from requester 1
        t_addr[1] = 7'h50; t_wdata[1] = 8'h11; t_rw[1] = 1'b1;
        apply_reqs(4'b0010);
        run_txn(2, 10, 8'hA5, 1'b0, gid, gc);
        check("read_gid", gid, 1);
        check("read_rdata", 32'(bus.rsp_rdata), 32'hA5);
        $display("txn read: id=%0d rdata=%02h err=%0d", bus.rsp_id, bus.rsp_rdata, bus.rsp_err);

        // round robin right after a reset, back-to-back grants at minimum spacing
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        model_last = NREQ - 1;
        for (int i = 0; i < NREQ; i++) begin
            t_addr[i] = 7'($urandom); t_rw[i] = 1'($urandom); t_wdata[i] = 8'($urandom);
        end
        apply_reqs(4'b0111);
        prev_gc = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) apply_reqs(4'b0101);
            run_txn(2, 5, 8'($urandom), 1'b1, gid, gc);
            check("rr_order", gid, exp_rr[i]);
            if (i > 0) check("rr_spacing", gc - prev_gc, EN + 3);
            prev_gc = gc;
            $display("txn rr[%0d]: id=%0d rdata=%02h", i, bus.rsp_id, bus.rsp_rdata);
        end
        apply_reqs('0);

        // stale ready: high through ISSUE, low 30 cycles, then high
        apply_reqs(4'b1000);
        run_txn(EN + 1, 30, 8'h5A, 1'b0, gid, gc);
        check("stale_gid", gid, 3);
        $display("txn stale: id=%0d rdata=%02h", bus.rsp_id, bus.rsp_rdata);

        // reset while waiting on the bridge
        apply_reqs(4'b0010);
        got = 1'b0;
        for (int w = 0; w < 60 && !got; w++) begin
            tick();
            if (bus.req_ready != '0) got = 1'b1;
        end
        check("rstw_grant_seen", 32'(got), 32'd1);
        check("rstw_grant", 32'(bus.req_ready), 32'b0010);
        bus.req_valid = '0;
        bus.i2c_ready = 1'b0;
        repeat (EN + 5) tick();
        check("rstw_in_wait", 32'({bus.busy, bus.enable}), 32'b10);
        #2 rst_n = 1'b0;
        #1;
        check("rstw_enable", 32'(bus.enable), 32'd0);
        check("rstw_busy", 32'(bus.busy), 32'd0);
        check("rstw_addr", 32'(bus.i2c_addr), 32'd0);
        check("rstw_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        for (int i = 0; i < 3; i++) begin
            bus.i2c_ready = (i == 1);
            tick();
            check("rstw_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        bus.i2c_ready = 1'b1;
        model_last = NREQ - 1;
        apply_reqs(4'b0101);
        run_txn(4, 8, 8'hC3, 1'b0, gid, gc);
        check("rstw_next_gid", gid, 0);
        $display("txn after reset: id=%0d rdata=%02h", bus.rsp_id, bus.rsp_rdata);
        apply_reqs('0);

        // randomized transactions
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                t_addr[i] = 7'($urandom); t_rw[i] = 1'($urandom); t_wdata[i] = 8'($urandom);
            end
            apply_reqs(NREQ'($urandom_range(1, (1 << NREQ) - 1)));
            ls = $urandom_range(1, 25);
            ll = $urandom_range(1, 40);
            run_txn(ls, ll, 8'($urandom), 1'($urandom), gid, gc);
            $display("txn rand[%0d]: id=%0d rdata=%02h ls=%0d ll=%0d", n, bus.rsp_id, bus.rsp_rdata, ls, ll);
            apply_reqs('0);
        end

`ifdef I2C_ARB_TIMEOUT_EN
        // watchdog abort with ready stuck low
        t_rw[3] = 1'b1;
        apply_reqs(4'b1000);
        bus.i2c_ready = 1'b0;
        bus.i2c_data_out = 8'hFF;
        got = 1'b0;
        for (int w = 0; w < 60 && !got; w++) begin
            tick();
            if (bus.req_ready != '0) got = 1'b1;
        end
        check("to_grant_seen", 32'(got), 32'd1);
        bus.req_valid = '0;
        rk = -1;
        for (int k = 1; k <= 400 && rk < 0; k++) begin
            tick();
            if (bus.rsp_valid) rk = k;
        end
        check("to_cycle", rk, TO);
        check("to_err", 32'(bus.rsp_err), 32'd1);
        check("to_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("to_id", 32'(bus.rsp_id), 32'd3);
        check("to_enable", 32'(bus.enable), 32'd0);
        tick();
        check("to_busy_fall", 32'(bus.busy), 32'd0);
        $display("txn timeout: id=%0d err=%0d", bus.rsp_id, bus.rsp_err);
        bus.i2c_ready = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
